// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: CMD0, CMD8, then CMD55/ACMD41 until ready, driving sd_controller.
// Optional per-command response watchdog enabled with `define SD_INIT_WATCHDOG_EN (err_code 5 on timeout).
module sd_init_sequencer #(
  parameter int POWERUP_CYCLES = 64,
  parameter int CMD0_RETRIES   = 8,
  parameter int ACMD41_RETRIES = 1000,
  parameter int CMD_TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  err_code,
  output logic        card_v2,
  output logic [5:0]  sd_cmd,
  output logic [31:0] sd_arg,
  output logic [6:0]  sd_crc,
  output logic [2:0]  sd_nresponse,
  output logic        sd_start,
  input  logic        sd_done,
  input  logic [7:0]  R1
);
  localparam int PW_W  = $clog2(POWERUP_CYCLES + 1);
  localparam int C0_W  = $clog2(CMD0_RETRIES + 1);
  localparam int A41_W = $clog2(ACMD41_RETRIES + 1);
  localparam logic [PW_W-1:0]  PW_LAST = PW_W'(POWERUP_CYCLES - 1);
  localparam logic [C0_W-1:0]  C0_MAX  = C0_W'(CMD0_RETRIES);
  localparam logic [A41_W-1:0] A41_MAX = A41_W'(ACMD41_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_ISSUE, S_WAIT, S_EVAL, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41
  } sel_t;

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [PW_W-1:0]  pw_cnt_q, pw_cnt_d;
  logic [C0_W-1:0]  c0_cnt_q, c0_cnt_d, c0_inc;
  logic [A41_W-1:0] a41_cnt_q, a41_cnt_d, a41_inc;
  logic [7:0]       r1_q, r1_d;
  logic             init_busy_q, init_busy_d;
  logic             init_done_q, init_done_d;
  logic             init_error_q, init_error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             card_v2_q, card_v2_d;
  logic [5:0]       sd_cmd_q, sd_cmd_d;
  logic [31:0]      sd_arg_q, sd_arg_d;
  logic [6:0]       sd_crc_q, sd_crc_d;
  logic [2:0]       sd_nresp_q, sd_nresp_d;
  logic             sd_start_q, sd_start_d;
`ifdef SD_INIT_WATCHDOG_EN
  localparam int WD_W = $clog2(CMD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(CMD_TIMEOUT - 1);
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pw_cnt_d     = pw_cnt_q;
    c0_cnt_d     = c0_cnt_q;
    a41_cnt_d    = a41_cnt_q;
    r1_d         = r1_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    err_code_d   = err_code_q;
    card_v2_d    = card_v2_q;
    sd_cmd_d     = sd_cmd_q;
    sd_arg_d     = sd_arg_q;
    sd_crc_d     = sd_crc_q;
    sd_nresp_d   = sd_nresp_q;
    c0_inc       = (c0_cnt_q == C0_MAX) ? c0_cnt_q : c0_cnt_q + 1'b1;
    a41_inc      = (a41_cnt_q == A41_MAX) ? a41_cnt_q : a41_cnt_q + 1'b1;
`ifdef SD_INIT_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // A new run from DONE/ERROR wipes the previous result before power-up.
        if (init_start || state_q == S_IDLE) begin
          init_done_d  = 1'b0;
          init_error_d = 1'b0;
          err_code_d   = 3'd0;
          card_v2_d    = 1'b0;
          c0_cnt_d     = '0;
          a41_cnt_d    = '0;
        end
        if (init_start) begin
          state_d  = S_PWRUP;
          pw_cnt_d = '0;
        end
      end
      S_PWRUP: begin
        if (pw_cnt_q == PW_LAST) begin
          state_d = S_ISSUE;
          sel_d   = C_CMD0;
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SD_INIT_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (sd_done) begin
          r1_d    = R1;
          state_d = S_EVAL;
        end
`ifdef SD_INIT_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          state_d      = S_ERROR;
          init_error_d = 1'b1;
          err_code_d   = 3'd5;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      S_EVAL: begin
        state_d = S_ISSUE;
        case (sel_q)
          C_CMD0: begin
            if (r1_q == 8'h01) begin
              sel_d = C_CMD8;
            end else begin
              c0_cnt_d = c0_inc;
              if (c0_inc == C0_MAX) begin
                state_d      = S_ERROR;
                init_error_d = 1'b1;
                err_code_d   = 3'd1;
              end
            end
          end
          C_CMD8: begin
            if (r1_q == 8'h01 || r1_q == 8'h05) begin
              card_v2_d = (r1_q == 8'h01);
              sel_d     = C_CMD55;
            end else begin
              state_d      = S_ERROR;
              init_error_d = 1'b1;
              err_code_d   = 3'd2;
            end
          end
          C_CMD55: begin
            if (r1_q == 8'h00 || r1_q == 8'h01) begin
              sel_d = C_ACMD41;
            end else begin
              state_d      = S_ERROR;
              init_error_d = 1'b1;
              err_code_d   = 3'd4;
            end
          end
          default: begin
            if (r1_q == 8'h00) begin
              state_d     = S_DONE;
              init_done_d = 1'b1;
            end else if (r1_q == 8'h01) begin
              a41_cnt_d = a41_inc;
              sel_d     = C_CMD55;
              if (a41_inc == A41_MAX) begin
                state_d      = S_ERROR;
                init_error_d = 1'b1;
                err_code_d   = 3'd3;
              end
            end else begin
              state_d      = S_ERROR;
              init_error_d = 1'b1;
              err_code_d   = 3'd4;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Command fields are latched on entry to ISSUE and stay put through WAIT.
    if (state_d == S_ISSUE) begin
      case (sel_d)
        C_CMD0: begin
          sd_cmd_d = 6'd0;  sd_arg_d = 32'h0;        sd_crc_d = 7'h4A; sd_nresp_d = 3'd0;
        end
        C_CMD8: begin
          sd_cmd_d = 6'd8;  sd_arg_d = 32'h000001AA; sd_crc_d = 7'h43; sd_nresp_d = 3'd4;
        end
        C_CMD55: begin
          sd_cmd_d = 6'd55; sd_arg_d = 32'h0;        sd_crc_d = 7'h32; sd_nresp_d = 3'd0;
        end
        default: begin
          sd_cmd_d   = 6'd41;
          sd_arg_d   = card_v2_d ? 32'h40000000 : 32'h0;
          sd_crc_d   = card_v2_d ? 7'h3B : 7'h72;
          sd_nresp_d = 3'd0;
        end
      endcase
    end

    sd_start_d  = (state_d == S_ISSUE);
    init_busy_d = (state_d == S_PWRUP) || (state_d == S_ISSUE) ||
                  (state_d == S_WAIT)  || (state_d == S_EVAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= C_CMD0;
      pw_cnt_q     <= '0;
      c0_cnt_q     <= '0;
      a41_cnt_q    <= '0;
      r1_q         <= 8'h0;
      init_busy_q  <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      err_code_q   <= 3'd0;
      card_v2_q    <= 1'b0;
      sd_cmd_q     <= 6'd0;
      sd_arg_q     <= 32'h0;
      sd_crc_q     <= 7'h0;
      sd_nresp_q   <= 3'd0;
      sd_start_q   <= 1'b0;
`ifdef SD_INIT_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pw_cnt_q     <= pw_cnt_d;
      c0_cnt_q     <= c0_cnt_d;
      a41_cnt_q    <= a41_cnt_d;
      r1_q         <= r1_d;
      init_busy_q  <= init_busy_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      err_code_q   <= err_code_d;
      card_v2_q    <= card_v2_d;
      sd_cmd_q     <= sd_cmd_d;
      sd_arg_q     <= sd_arg_d;
      sd_crc_q     <= sd_crc_d;
      sd_nresp_q   <= sd_nresp_d;
      sd_start_q   <= sd_start_d;
`ifdef SD_INIT_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign init_busy    = init_busy_q;
  assign init_done    = init_done_q;
  assign init_error   = init_error_q;
  assign err_code     = err_code_q;
  assign card_v2      = card_v2_q;
  assign sd_cmd       = sd_cmd_q;
  assign sd_arg       = sd_arg_q;
  assign sd_crc       = sd_crc_q;
  assign sd_nresponse = sd_nresp_q;
  assign sd_start     = sd_start_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Scoreboard bench for sd_init_sequencer: a card model answers commands from an R1 script,
// and a sequence-level reference model predicts every strobe and the final outcome.
module tb_sd_init_sequencer;
  localparam int P    = 16;
  localparam int C0R  = 3;
  localparam int A41R = 4;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        rst, init_start, init_busy, init_done, init_error, card_v2;
  logic [2:0]  err_code, sd_nresponse;
  logic [5:0]  sd_cmd;
  logic [31:0] sd_arg;
  logic [6:0]  sd_crc;
  logic        sd_start, sd_done;
  logic [7:0]  R1;

  sd_init_sequencer #(
    .POWERUP_CYCLES(P), .CMD0_RETRIES(C0R), .ACMD41_RETRIES(A41R), .CMD_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done), .init_error(init_error), .err_code(err_code), .card_v2(card_v2),
    .sd_cmd(sd_cmd), .sd_arg(sd_arg), .sd_crc(sd_crc), .sd_nresponse(sd_nresponse),
    .sd_start(sd_start), .sd_done(sd_done), .R1(R1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          fin;
    logic [47:0] sv;   // {cmd, arg, crc, nresp}
    logic [5:0]  fv;   // {done, error, code, v2}
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  logic [7:0] script[$];
  logic [7:0] card_q[$];
  int         exp_strobes;
  int         total = 0, bad = 0;
  int         nxt_strobe = -1, fin_lo = -1, fin_hi = -1;
  int         strobe_cnt = 0, fin_cnt = 0;
  int         card_fixed = 0;
  bit         card_mute = 1'b0;
  bit         fin_prev = 1'b0;
  logic [7:0] pool [8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h05, 8'hFF, 8'h81, 8'h04};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_strobe(input logic [5:0] c, input logic [31:0] a, input logic [6:0] crc,
                             input logic [2:0] nr);
    exp_q.push_back('{fin: 1'b0, sv: {c, a, crc, nr}, fv: 6'h0});
    exp_strobes++;
  endtask

  task automatic push_fin(input bit d, input bit e, input logic [2:0] code, input bit v2);
    exp_q.push_back('{fin: 1'b1, sv: 48'h0, fv: {d, e, code, v2}});
  endtask

  // Reference: walk the card's answers through the documented init procedure.
  task automatic build_expect();
    int i;
    bit v2;
    logic [7:0] r;
    exp_q.delete();
    exp_strobes = 0;
    i  = 0;
    v2 = 1'b0;
    for (int a = 1; ; a++) begin
      push_strobe(6'd0, 32'h0, 7'h4A, 3'd0);
      r = script[i]; i++;
      if (r == 8'h01) break;
      if (a >= C0R) begin push_fin(1'b0, 1'b1, 3'd1, 1'b0); return; end
    end
    push_strobe(6'd8, 32'h000001AA, 7'h43, 3'd4);
    r = script[i]; i++;
    if (r == 8'h01) v2 = 1'b1;
    else if (r == 8'h05) v2 = 1'b0;
    else begin push_fin(1'b0, 1'b1, 3'd2, 1'b0); return; end
    for (int a = 1; ; a++) begin
      push_strobe(6'd55, 32'h0, 7'h32, 3'd0);
      r = script[i]; i++;
      if (r != 8'h00 && r != 8'h01) begin push_fin(1'b0, 1'b1, 3'd4, v2); return; end
      push_strobe(6'd41, v2 ? 32'h40000000 : 32'h0, v2 ? 7'h3B : 7'h72, 3'd0);
      r = script[i]; i++;
      if (r == 8'h00) begin push_fin(1'b1, 1'b0, 3'd0, v2); return; end
      if (r != 8'h01) begin push_fin(1'b0, 1'b1, 3'd4, v2); return; end
      if (a >= A41R) begin push_fin(1'b0, 1'b1, 3'd3, v2); return; end
    end
  endtask

  // Card model: answers each strobe after a delay with the next scripted R1.
  initial begin
    sd_done = 1'b0;
    R1      = 8'h00;
    forever begin
      @(negedge clk);
      if (sd_start) begin
        if (card_mute) begin
          fin_lo = cyc + TMO;
          fin_hi = cyc + TMO + 1;
        end else begin
          repeat ((card_fixed > 0) ? card_fixed : $urandom_range(1, 4)) @(posedge clk);
          #1;
          sd_done = 1'b1;
          R1      = (card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
          nxt_strobe = cyc + 2;
          fin_lo     = cyc + 2;
          fin_hi     = cyc + 2;
          @(posedge clk);
          #1;
          sd_done = 1'b0;
          R1      = 8'h00;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes or finishes.
  initial begin
    forever begin
      @(negedge clk);
      if (sd_start) begin
        strobe_cnt++;
        total++;
        if (exp_q.size() == 0 || exp_q[0].fin) begin
          bad++;
          $display("FAIL strobe_unexpected: got cmd %0d at cycle %0d, want no strobe", sd_cmd, cyc);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_fields", {sd_cmd, sd_arg, sd_crc, sd_nresponse}, ev.sv);
          chk("strobe_cycle", cyc, nxt_strobe);
        end
      end
      if ((init_done || init_error) && !fin_prev) begin
        fin_cnt++;
        total++;
        if (exp_q.size() == 0 || !exp_q[0].fin) begin
          bad++;
          $display("FAIL finish_unexpected: got done=%0b err=%0b code=%0d, want a strobe first",
                   init_done, init_error, err_code);
        end else begin
          ev = exp_q.pop_front();
          chk("finish_flags", {init_done, init_error, err_code, card_v2}, ev.fv);
        end
        chk("finish_busy", init_busy, 1'b0);
        total++;
        if (cyc < fin_lo || cyc > fin_hi) begin
          bad++;
          $display("FAIL finish_cycle: got %0d want %0d..%0d", cyc, fin_lo, fin_hi);
        end
      end
      fin_prev = init_done || init_error;
    end
  end

  task automatic start_and_wait();
    int fc, sc;
    fc = fin_cnt;
    sc = strobe_cnt;
    card_q = script;
    @(posedge clk); #1;
    init_start = 1'b1;
    nxt_strobe = cyc + 1 + P;
    @(posedge clk); #1;
    init_start = 1'b0;
    @(negedge clk);
    chk("busy_rise", {init_busy, init_done, init_error, err_code, card_v2}, 7'b1000000);
    for (int k = 0; k < 3000 && fin_cnt == fc; k++) @(posedge clk);
    total++;
    if (fin_cnt == fc) begin
      bad++;
      $display("FAIL run_timeout: got no done/error in 3000 cycles, want one");
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("strobe_count", strobe_cnt - sc, exp_strobes);
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic run_script();
    build_expect();
    start_and_wait();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, want $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int sc;
    rst        = 1'b1;
    init_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {init_busy, init_done, init_error, err_code, card_v2, sd_cmd, sd_arg,
                          sd_crc, sd_nresponse, sd_start}, 64'h0);

    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};  // v2 card
    run_script();
    script = '{8'h01, 8'h05, 8'h01, 8'h00};                              // v1 card
    run_script();
    script = '{8'hFF, 8'hFF, 8'hFF};                                     // CMD0 never idle
    run_script();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_script();                                                        // ACMD41 stuck
    script = '{8'h01, 8'h05, 8'h00, 8'h00};                              // restart after error
    run_script();
    script = '{8'h01, 8'h09};                                            // bad CMD8
    run_script();
    script = '{8'h01, 8'h01, 8'h04};                                     // bad CMD55
    run_script();
    script = '{8'h01, 8'h05, 8'h01, 8'h81};                              // ACMD41 bit 7 set
    run_script();
    script = '{8'hFF, 8'h01, 8'h01, 8'h00, 8'h00};                       // one CMD0 retry
    run_script();

    // Reset while waiting on CMD8; the late sd_done must then be ignored.
    exp_q.delete();
    exp_strobes = 0;
    push_strobe(6'd0, 32'h0, 7'h4A, 3'd0);
    push_strobe(6'd8, 32'h000001AA, 7'h43, 3'd4);
    card_q     = '{8'h01};
    card_fixed = 8;
    sc         = strobe_cnt;
    @(posedge clk); #1;
    init_start = 1'b1;
    nxt_strobe = cyc + 1 + P;
    @(posedge clk); #1;
    init_start = 1'b0;
    for (int k = 0; k < 400 && strobe_cnt < sc + 2; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait", {init_busy, init_done, init_error, err_code, card_v2, sd_cmd, sd_arg,
                         sd_crc, sd_nresponse, sd_start}, 64'h0);
    repeat (15) @(posedge clk);
    chk("rst_done_ignored", {strobe_cnt - sc, 1'b0, init_busy}, {32'd2, 1'b0, 1'b0});
    exp_q.delete();
    card_fixed = 0;

    for (int n = 0; n < 12; n++) begin
      script.delete();
      for (int j = 0; j < 16; j++) script.push_back(pool[$urandom_range(0, 7)]);
      run_script();
    end

`ifdef SD_INIT_WATCHDOG_EN
    card_mute = 1'b1;
    exp_q.delete();
    exp_strobes = 0;
    push_strobe(6'd0, 32'h0, 7'h4A, 3'd0);
    push_fin(1'b0, 1'b1, 3'd5, 1'b0);
    script.delete();
    start_and_wait();
    card_mute = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
